// File: rtl/spm_lsu_pkg.sv
// Shared types and constants for the scratchpad load/store unit.
// Provides the access-size encoding, the response FIFO depth, the scratchpad
// read latency, the per-request tag that rides the read pipeline and the
// response record returned to the core.
package spm_lsu_pkg;

    typedef enum logic [1:0] {
        SPM_SIZE_BYTE = 2'd0,
        SPM_SIZE_HALF = 2'd1,
        SPM_SIZE_WORD = 2'd2
    } spm_size_e;

    localparam int SPM_LSU_RSP_DEPTH = 3;
    localparam int SPM_READ_LATENCY  = 2;
    localparam int SPM_LSU_CNT_W     = $clog2(SPM_LSU_RSP_DEPTH + 1);

    typedef struct packed {
        logic      valid;
        logic      we;
        spm_size_e size;
        logic      sgn;
        logic [1:0] addrLow;
        logic      error;
    } spm_lsu_tag_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } spm_lsu_rsp_t;

    // Encoding 3 is not a real size; the core gets word behaviour for it.
    function automatic spm_size_e normSize(input logic [1:0] s);
        case (s)
            2'd0:    return SPM_SIZE_BYTE;
            2'd1:    return SPM_SIZE_HALF;
            default: return SPM_SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/spm_lsu_rsp_fifo.sv
// Small synchronous FIFO holding responses the core has not yet taken.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push, pushData    - write one response at the tail
//   pop               - drop the head entry (caller only pops when non-empty)
//   head              - current head entry (undefined when empty)
//   empty, count      - occupancy status
// Reset empties the FIFO; stored entries are not cleared.
module spm_lsu_rsp_fifo
    import spm_lsu_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  spm_lsu_rsp_t             pushData,
    input  logic                     pop,
    output spm_lsu_rsp_t             head,
    output logic                     empty,
    output logic [SPM_LSU_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(SPM_LSU_RSP_DEPTH);

    spm_lsu_rsp_t     mem [SPM_LSU_RSP_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SPM_LSU_RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rdPtr];
    assign empty = (count == '0);

endmodule

// File: rtl/spm_lsu.sv
// Core-side load/store front end for the scratchpad.
// Decodes the scratchpad window, drives the scratchpad core port with byte
// enables and lane-replicated store data, follows the two-cycle registered
// read latency with a tag pipeline, extracts and extends load data, and
// buffers responses so the core can stall them.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   reqValid/reqReady       - request handshake from the memory stage
//   reqAddress, reqWe, reqSize, reqSigned, reqWriteData - request fields
//   rspValid/rspReady       - response handshake back to the core
//   rspData, rspError       - extended load data / window or alignment error
//   spmCs, spmWe, spmAddress, spmByteEnables, dataToSpm - scratchpad drive
//   dataFromSpm             - scratchpad read data, two cycles after spmCs
// Build option: define SPM_LSU_ALIGN_CHECK_EN to report misaligned half/word
// accesses as errors; otherwise the low address bits are forced to alignment.
module spm_lsu
    import spm_lsu_pkg::*;
#(
    parameter logic [31:0] spmBaseAddress = 32'hC0000000,
    parameter int unsigned spmSizeInBytes = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddress,
    input  logic        reqWe,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqWriteData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic        rspError,
    output logic        spmCs,
    output logic        spmWe,
    output logic [17:0] spmAddress,
    output logic [3:0]  spmByteEnables,
    output logic [31:0] dataToSpm,
    input  logic [31:0] dataFromSpm
);

    localparam int unsigned WIN_BITS    = $clog2(spmSizeInBytes);
    localparam logic [31:0] OFFSET_MASK = 32'(spmSizeInBytes - 1);

    function automatic logic [3:0] laneEnables(input spm_size_e sz, input logic [1:0] low);
        case (sz)
            SPM_SIZE_BYTE: return 4'b0001 << low;
            SPM_SIZE_HALF: return 4'b0011 << {low[1], 1'b0};
            default:       return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input spm_size_e sz, input logic [31:0] wd);
        case (sz)
            SPM_SIZE_BYTE: return {4{wd[7:0]}};
            SPM_SIZE_HALF: return {2{wd[15:0]}};
            default:       return wd;
        endcase
    endfunction

    function automatic logic [31:0] extractLoad(input logic [31:0] raw, input spm_size_e sz,
                                                input logic sgn, input logic [1:0] low);
        logic [31:0] sh;
        sh = raw >> {low, 3'b000};
        case (sz)
            SPM_SIZE_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
            SPM_SIZE_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
            default:       return sh;
        endcase
    endfunction

    logic [SPM_LSU_CNT_W-1:0] pendingCount;
    spm_size_e                size;
    logic [1:0]               effLow;
    logic                     misaligned;
    logic                     inWindow;
    logic                     reqError;
    logic                     accept;
    logic                     drive;
    logic [31:0]              winOffset;
    spm_lsu_tag_t             tagIn;
    spm_lsu_tag_t             tag_p1;
    spm_lsu_tag_t             tag_p2;
    spm_lsu_rsp_t             rspNow;
    spm_lsu_rsp_t             rspSel;
    spm_lsu_rsp_t             fifoHead;
    logic                     fifoEmpty;
    logic [SPM_LSU_CNT_W-1:0] fifoCount;
    logic                     fifoPush;
    logic                     fifoPop;
    logic                     rspFire;

    // ---- stage 0: decode and scratchpad drive (combinational) ----
    always_comb begin
        size       = normSize(reqSize);
        effLow     = reqAddress[1:0];
        misaligned = 1'b0;
`ifdef SPM_LSU_ALIGN_CHECK_EN
        misaligned = ((size == SPM_SIZE_HALF) && reqAddress[0]) ||
                     ((size == SPM_SIZE_WORD) && (reqAddress[1:0] != 2'b00));
`else
        if (size == SPM_SIZE_HALF) begin
            effLow[0] = 1'b0;
        end else if (size == SPM_SIZE_WORD) begin
            effLow = 2'b00;
        end
`endif
    end

    // Credit limit uses registered state only, so reqReady never follows rspReady.
    assign reqReady  = !reset && (pendingCount < SPM_LSU_CNT_W'(SPM_LSU_RSP_DEPTH));
    assign inWindow  = (reqAddress >> WIN_BITS) == (spmBaseAddress >> WIN_BITS);
    assign reqError  = !inWindow || misaligned;
    assign accept    = reqValid && reqReady;
    assign drive     = accept && !reqError;
    assign winOffset = reqAddress & OFFSET_MASK;

    assign spmCs          = drive;
    assign spmWe          = drive && reqWe;
    assign spmAddress     = drive ? 18'(winOffset >> 2) : '0;
    assign spmByteEnables = drive ? laneEnables(size, effLow) : '0;
    assign dataToSpm      = drive ? replicate(size, reqWriteData) : '0;

    assign tagIn = '{valid: accept, we: reqWe, size: size, sgn: reqSigned,
                     addrLow: effLow, error: reqError};

    // ---- stage 1/2: tag pipeline matching the scratchpad read latency ----
    always_ff @(posedge clock) begin
        tag_p1 <= tagIn;
        tag_p2 <= tag_p1;
        if (reset) begin
            tag_p1.valid <= 1'b0;
            tag_p2.valid <= 1'b0;
            pendingCount <= '0;
        end else begin
            case ({accept, rspFire})
                2'b10:   pendingCount <= pendingCount + 1'b1;
                2'b01:   pendingCount <= pendingCount - 1'b1;
                default: pendingCount <= pendingCount;
            endcase
        end
    end

    // ---- stage 2: load extraction and response select ----
    always_comb begin
        rspNow.data  = '0;
        rspNow.error = tag_p2.valid && tag_p2.error;
        if (tag_p2.valid && !tag_p2.we && !tag_p2.error) begin
            rspNow.data = extractLoad(dataFromSpm, tag_p2.size, tag_p2.sgn, tag_p2.addrLow);
        end
    end

    // Older buffered responses always go first; stage 2 bypasses only an empty FIFO.
    assign rspSel   = fifoEmpty ? rspNow : fifoHead;
    assign rspValid = (fifoCount != '0) || tag_p2.valid;
    assign rspData  = rspSel.data;
    assign rspError = rspSel.error;
    assign rspFire  = rspValid && rspReady;
    assign fifoPop  = !fifoEmpty && rspReady;
    assign fifoPush = tag_p2.valid && !(fifoEmpty && rspReady);

    spm_lsu_rsp_fifo u_rspFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (rspNow),
        .pop      (fifoPop),
        .head     (fifoHead),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

endmodule

// File: tb/tb_spm_lsu.sv
// Self-checking bench for spm_lsu: a scratchpad model with two-cycle read
// latency, a byte-level reference memory and a response scoreboard.
module tb_spm_lsu;

    localparam logic [31:0] BASE      = 32'hC0000000;
    localparam int          SPM_BYTES = 4096;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddress;
    logic        reqWe;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqWriteData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspError;
    logic        spmCs;
    logic        spmWe;
    logic [17:0] spmAddress;
    logic [3:0]  spmByteEnables;
    logic [31:0] dataToSpm;
    logic [31:0] dataFromSpm;

    spm_lsu #(.spmBaseAddress(BASE), .spmSizeInBytes(SPM_BYTES)) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqAddress     (reqAddress),
        .reqWe          (reqWe),
        .reqSize        (reqSize),
        .reqSigned      (reqSigned),
        .reqWriteData   (reqWriteData),
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspData        (rspData),
        .rspError       (rspError),
        .spmCs          (spmCs),
        .spmWe          (spmWe),
        .spmAddress     (spmAddress),
        .spmByteEnables (spmByteEnables),
        .dataToSpm      (dataToSpm),
        .dataFromSpm    (dataFromSpm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errCnt = 0;
    int chkCnt = 0;
    int cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scratchpad model: registered read, data presented two cycles after spmCs.
    logic [31:0] spmMem [1024];
    logic [31:0] rd1;
    logic [31:0] rd2;
    always @(posedge clock) begin
        if (spmCs) begin
            if (spmWe) begin
                for (int i = 0; i < 4; i++) begin
                    if (spmByteEnables[i]) spmMem[spmAddress[9:0]][8*i +: 8] <= dataToSpm[8*i +: 8];
                end
            end
            rd1 <= spmMem[spmAddress[9:0]];
        end
        rd2 <= rd1;
    end
    assign dataFromSpm = rd2;

    // Reference memory at byte granularity, updated in acceptance order.
    logic [7:0] refMem [SPM_BYTES];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        bit          chkLat;
    } exp_t;
    exp_t q[$];
    bit chkLat = 1'b0;
    bit rndRsp = 1'b0;

    function automatic exp_t model(input logic [31:0] addr, input logic we, input logic [1:0] sz,
                                   input logic sg, input logic [31:0] wd);
        exp_t        e;
        int          nb;
        logic [31:0] a;
        logic [31:0] off;
        logic [31:0] v;
        logic        bad;
        e.data = 32'h0;
        e.err  = 1'b0;
        e.cyc  = cyc;
        e.chkLat = chkLat;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a   = addr;
        bad = (addr < BASE) || (addr >= BASE + SPM_BYTES);
`ifdef SPM_LSU_ALIGN_CHECK_EN
        if ((nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00)) bad = 1'b1;
`else
        a = a & ~(32'(nb) - 32'd1);
`endif
        if (bad) begin
            e.err = 1'b1;
            return e;
        end
        off = a - BASE;
        if (we) begin
            for (int i = 0; i < nb; i++) refMem[off + 32'(i)] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = refMem[off + 32'(i)];
            if (sg && nb < 4 && v[8*nb-1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            e.data = v;
        end
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on each consumed response.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            if (rspValid && rspReady) begin
                if (q.size() == 0) begin
                    check_val("rsp_unexpected", 32'(rspValid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check_val("rsp_data", rspData, e.data);
                    check_val("rsp_error", 32'(rspError), 32'(e.err));
                    if (e.chkLat) check_val("rsp_latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            if (reqValid && reqReady) begin
                q.push_back(model(reqAddress, reqWe, reqSize, reqSigned, reqWriteData));
            end
        end
    end

    logic        capCs;
    logic        capWe;
    logic [17:0] capAddr;
    logic [3:0]  capBe;
    logic [31:0] capData;

    task automatic doReq(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        int n = 0;
        reqValid = 1'b1; reqAddress = a; reqWe = we; reqSize = sz; reqSigned = sg; reqWriteData = wd;
        if (rndRsp) rspReady = ($urandom_range(0, 3) != 0);
        #1;
        while (!reqReady && n < 100) begin
            @(posedge clock); #1;
            if (rndRsp) rspReady = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        if (n >= 100) check_val("req_accept_timeout", 32'(n), 32'd0);
        capCs = spmCs; capWe = spmWe; capAddr = spmAddress; capBe = spmByteEnables; capData = dataToSpm;
        @(posedge clock); #1;
        reqValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rspReady = 1'b1;
        while (q.size() != 0 && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check_val("drain_left", 32'(q.size()), 32'd0);
    endtask

    logic [31:0] ld [5];
    int          idx;
    int          guard;

    initial begin
        for (int i = 0; i < 1024; i++) spmMem[i] = 32'h0;
        for (int i = 0; i < SPM_BYTES; i++) refMem[i] = 8'h0;
        rd1 = 32'h0; rd2 = 32'h0;
        reset = 1'b1; reqValid = 1'b0; reqAddress = 32'h0; reqWe = 1'b0; reqSize = 2'd0;
        reqSigned = 1'b0; reqWriteData = 32'h0; rspReady = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        check_val("rst_reqReady", 32'(reqReady), 32'd0);
        check_val("rst_rspValid", 32'(rspValid), 32'd0);
        check_val("rst_rspData", rspData, 32'd0);
        check_val("rst_rspError", 32'(rspError), 32'd0);
        check_val("rst_spm_drive", {spmCs, spmWe, spmByteEnables, spmAddress, 8'h0}, 32'd0);
        check_val("rst_dataToSpm", dataToSpm, 32'd0);
        reset = 1'b0;
        #1;
        check_val("post_rst_reqReady", 32'(reqReady), 32'd1);
        @(posedge clock); #1;

        // Word store then signed byte load.
        chkLat = 1'b1;
        doReq(BASE + 32'h10, 1'b1, 2'd2, 1'b0, 32'h80817F10);
        check_val("st_word_cs_we", {30'h0, capCs, capWe}, 32'd3);
        check_val("st_word_be", 32'(capBe), 32'hF);
        check_val("st_word_addr", 32'(capAddr), 32'h4);
        check_val("st_word_data", capData, 32'h80817F10);
        doReq(BASE + 32'h12, 1'b0, 2'd0, 1'b1, 32'h0);
        check_val("ld_byte_be", 32'(capBe), 32'h4);
        check_val("ld_byte_we", 32'(capWe), 32'd0);

        // Half store at the top of the window, then unsigned half load.
        doReq(BASE + 32'hFFE, 1'b1, 2'd1, 1'b0, 32'h1234BEEF);
        check_val("st_half_addr", 32'(capAddr), 32'h3FF);
        check_val("st_half_be", 32'(capBe), 32'hC);
        check_val("st_half_data", capData, 32'hBEEFBEEF);
        doReq(BASE + 32'hFFE, 1'b0, 2'd1, 1'b0, 32'h0);
        check_val("ld_half_cs", 32'(capCs), 32'd1);

        // Out-of-window load.
        doReq(BASE + 32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
        check_val("oow_cs", 32'(capCs), 32'd0);
        doReq(32'hBFFFFFFC, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        check_val("below_win_cs", 32'(capCs), 32'd0);

        // Misaligned word load from word address 1.
        doReq(BASE + 32'h4, 1'b1, 2'd2, 1'b0, 32'h11223344);
        doReq(BASE + 32'h6, 1'b0, 2'd2, 1'b0, 32'h0);
`ifdef SPM_LSU_ALIGN_CHECK_EN
        check_val("misal_cs", 32'(capCs), 32'd0);
`else
        check_val("misal_cs", 32'(capCs), 32'd1);
        check_val("misal_addr", 32'(capAddr), 32'd1);
        check_val("misal_be", 32'(capBe), 32'hF);
`endif
        doReq(BASE + 32'h7, 1'b0, 2'd1, 1'b1, 32'h0);
        drain();

        // Back-pressure: 5 back-to-back loads with the core stalled.
        chkLat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld[i] = BASE + 32'h100 + 32'(4 * i);
            doReq(ld[i], 1'b1, 2'd2, 1'b0, 32'hA5000000 + 32'(i * 32'h01010101));
        end
        drain();
        rspReady = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            reqValid = 1'b1; reqAddress = ld[idx]; reqWe = 1'b0; reqSize = 2'd2; reqSigned = 1'b0;
            #1;
            if (reqReady) idx++;
            @(posedge clock); #1;
        end
        check_val("bp_accepted", 32'(idx), 32'd3);
        reqAddress = ld[idx];
        #1;
        check_val("bp_reqReady_low", 32'(reqReady), 32'd0);
        rspReady = 1'b1;
        #1;
        check_val("bp_reqReady_same_cycle", 32'(reqReady), 32'd0);
        @(posedge clock); #1;
        check_val("bp_reqReady_reassert", 32'(reqReady), 32'd1);
        guard = 0;
        while (idx < 5 && guard < 50) begin
            reqAddress = ld[idx];
            #1;
            if (reqReady) idx++;
            @(posedge clock); #1;
            guard++;
        end
        reqValid = 1'b0;
        check_val("bp_all_issued", 32'(idx), 32'd5);
        drain();

        // Random mix with random response stalls.
        rndRsp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 15));
                1:       a = BASE - 32'd1 - 32'($urandom_range(0, 3));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            doReq(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                rspReady = ($urandom_range(0, 1) != 0);
                @(posedge clock); #1;
            end
        end
        rndRsp = 1'b0;
        drain();

        // Reset with two loads in flight.
        doReq(BASE + 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
        doReq(BASE + 32'h100, 1'b0, 2'd2, 1'b0, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("rst_op_rspValid", 32'(rspValid), 32'd0);
        check_val("rst_op_pending", 32'(dut.pendingCount), 32'd0);
        check_val("rst_op_reqReady", 32'(reqReady), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_val("rst_op_reqReady_after", 32'(reqReady), 32'd1);
        check_val("rst_op_rspValid_after", 32'(rspValid), 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/spm_lsu.md
# spm_lsu

Core-side load/store front end for the 4 KiB scratchpad. It sits between the processor memory stage and the scratchpad's core port (`spmCs`/`spmWe`/`spmAddress`/`spmByteEnables`/`dataToSpm`/`dataFromSpm`). It performs the following:
- Decodes the scratchpad window.
- Generates byte enables and replicated store data.
- Tracks the scratchpad's two-cycle registered read latency.
- Extracts and sign- or zero-extends load data.
- Buffers responses so that the core can back-pressure them without losing data.

## Interface
- `spmBaseAddress`, default 32'hC0000000: byte base of the window. It must be aligned to `spmSizeInBytes`.
- `spmSizeInBytes`, default 4096: window size. It must be a power of two, from 4 to 1048576.
- `clock` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `reqValid` in 1: the core presents a request.
- `reqReady` out 1: the block accepts a request. Reset value 0.
- `reqAddress` in 32: byte address.
- `reqWe` in 1: 1 = store, 0 = load.
- `reqSize` in 2: 0 = byte, 1 = half, 2 = word. The value 3 is treated as word.
- `reqSigned` in 1: sign-extend the load result.
- `reqWriteData` in 32: store data, right-aligned.
- `rspValid` out 1: a response is available. Reset value 0.
- `rspReady` in 1: the core consumes the response.
- `rspData` out 32: extended load data. The value is 0 for stores and for errors. Reset value 0.
- `rspError` out 1: the access was outside the window, or was misaligned (see Configuration). Reset value 0.
- `spmCs` out 1: scratchpad select. Reset value 0.
- `spmWe` out 1: scratchpad write. Reset value 0.
- `spmAddress` out 18: word address within the window. Reset value 0.
- `spmByteEnables` out 4: byte lanes. Reset value 0.
- `dataToSpm` out 32: replicated store data. Reset value 0.
- `dataFromSpm` in 32: registered read data. It is valid two cycles after `spmCs`.

## Operation
- **Accept.** A request is accepted when `reqValid && reqReady`.
  - `reqReady = !reset && (pendingCount < 3)`.
  - `pendingCount` counts accepted requests whose response has not yet been consumed.
- **Window hit.** A request hits when `reqAddress[31:log2(size)] == spmBaseAddress[31:log2(size)]`.
  - `spmAddress = reqAddress[log2(size)-1:2]`, zero-extended to 18 bits.
- **Scratchpad drive.** `spmCs`, `spmWe`, `spmByteEnables` and `dataToSpm` are combinational.
  - They are driven only for accepted, in-window, non-erroring requests. Otherwise all of them are 0.
- **Byte enables.**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
- **Store data.**
  - Byte: `{4{wd[7:0]}}`.
  - Half: `{2{wd[15:0]}}`.
  - Word: `wd`.
- **Tag pipeline.** Every accepted request, including erroring ones, pushes a tag into a 2-stage shift register. The tag holds: valid, we, size, signed, `addr[1:0]`, and error.
- **Load extraction.** At stage 2, the load data is `dataFromSpm >> (8*addr[1:0])`, masked to the access size and extended according to `signed`.
- **Response bypass.** Stage-2 results go directly to `rsp*` when the response FIFO is empty. Otherwise they are written into the FIFO, which is 3 entries deep, and `rsp*` shows the FIFO head.
- **Back-pressure.** If `rspValid && !rspReady`, the stage-2 result is written into the FIFO and is not lost.
- **Ordering.** Responses are returned strictly in request order. Stores and errors also produce exactly one response each.
- **Count update.** `pendingCount` does +1 on accept and −1 on `rspValid && rspReady`. When both happen in the same cycle, the count is unchanged.
- **FIFO capacity.** Because of the credit limit, the FIFO can never overflow.
- **Reset during operation.** Reset clears the tag pipeline, the FIFO and `pendingCount`. In-flight responses are dropped.
  - Stores that were already presented to the scratchpad remain written.

## Timing
- **Latency.** A request accepted in cycle t drives `spmCs` in cycle t. Its response is on `rsp*` in cycle t+2 when the response path is unblocked.
- **Throughput.** One request per cycle with `rspReady` held at 1. In steady state `pendingCount` stays at 2.
- **Stall.** With `rspReady = 0`, at most 3 requests are accepted, after which `reqReady` = 0. `reqReady` reasserts in the cycle after a consume.
- **`reqReady`.** Depends only on registered state, never combinationally on `rspReady`.
- **Store then load.** A store at t followed by a load to the same word at t+1 returns the stored data. This is guaranteed by the scratchpad's port timing and needs no forwarding.

## Configuration
- **`SPM_LSU_ALIGN_CHECK_EN` defined:**
  - A half access with `addr[0] = 1`, or a word access with `addr[1:0] != 0`, is flagged as an error.
  - Such an access gets no `spmCs`, and returns `rspError = 1` with `rspData = 0`.
- **`SPM_LSU_ALIGN_CHECK_EN` undefined:**
  - The offending low address bits are forced to 0: `addr[0]` for half accesses, `addr[1:0]` for word accesses.
  - The access proceeds normally, and misalignment never sets `rspError`.

## Structure
- **Package `spm_lsu_pkg`:**
  - Size encodings `SPM_SIZE_BYTE`, `SPM_SIZE_HALF` and `SPM_SIZE_WORD`.
  - `SPM_LSU_RSP_DEPTH = 3`.
  - `SPM_READ_LATENCY = 2`.
  - Tag struct `spm_lsu_tag_t`.
  - Response struct `{data, error}`.
- **Sub-module `spm_lsu_rsp_fifo`:**
  - 3-entry synchronous FIFO of response structs.
  - Push/pop, with `empty` and `count` outputs.
  - Reset clears it to empty.

## Test plan
- **Word store then signed byte load.** Store word 32'h8081_7F10 to 32'hC000_0010. Then load a signed byte from 32'hC000_0012.
  - Byte enables are 4'b1111 for the store and 4'b0100 for the load.
  - The load response is 32'hFFFF_FF81, returned 2 cycles after acceptance.
- **Half store.** Store half 16'hBEEF to 32'hC000_0FFE.
  - `spmAddress` = 10'h3FF, `spmByteEnables` = 4'b1100, `dataToSpm` = 32'hBEEF_BEEF.
  - An unsigned half load from the same address returns 32'h0000_BEEF.
- **Out-of-window load.** Load from 32'hC000_1000.
  - `spmCs` stays 0.
  - Response arrives in cycle t+2 with `rspError = 1` and `rspData = 0`.
- **Back-pressure.** Hold `rspReady` = 0 and issue 5 back-to-back loads.
  - Exactly 3 are accepted, then `reqReady` = 0.
  - After `rspReady` is released, all 5 are eventually returned in order with correct data.
- **Misaligned word load.** Load a word from 32'hC000_0006.
  - With the macro defined: `rspError = 1` and no `spmCs`.
  - Without the macro: the data from word address 1 is returned with no error.
- **Reset during operation.** Assert `reset` with 2 loads in flight.
  - The next cycle shows `rspValid` = 0, `pendingCount` = 0 and `reqReady` = 0.
  - `reqReady` = 1 one cycle after `reset` deasserts.
